// File: rtl/stopwatch_display_scan_if.sv
// Digit inputs, live display controls and multiplexed display outputs of the stopwatch scanner.
interface stopwatch_display_scan_if;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       blank_lead;
    logic [3:0] blink_sel;
    logic       dp_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    modport master (
        output sec_ones, sec_tens, min_ones, min_tens, blank_lead, blink_sel, dp_en,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  sec_ones, sec_tens, min_ones, min_tens, blank_lead, blink_sel, dp_en,
        output an, seg, dp, frame_tick
    );
endinterface

// File: rtl/stopwatch_display_scan.sv
// Time-multiplexed 4-digit 7-segment driver with per-frame snapshot, lead blanking and blink.
module stopwatch_display_scan #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLINK_DIV   = 25
) (
    input logic                     clk,
    input logic                     reset,
    stopwatch_display_scan_if.slave bus
);
    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic [3:0]    snap_q [4];
    logic [3:0]    snap_d [4];
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_tick_q, frame_tick_d;

    logic          slot_end;
    logic          wrap;
    logic [3:0]    cur;
    logic          blank;
    logic          illegal;

    function automatic logic [6:0] dec7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_end      = (presc_q == PW'(REFRESH_DIV - 1));
        wrap          = slot_end && (idx_q == 2'd3);
        presc_d       = slot_end ? '0 : presc_q + 1'b1;
        idx_d         = slot_end ? idx_q + 2'd1 : idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        for (int i = 0; i < 4; i++) snap_d[i] = snap_q[i];
        if (wrap) begin
            snap_d[0] = bus.sec_ones;
            snap_d[1] = bus.sec_tens;
            snap_d[2] = bus.min_ones;
            snap_d[3] = bus.min_tens;
            if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Outputs reflect the current slot and are registered, so they trail idx_q by one clock.
    always_comb begin
        cur     = snap_q[idx_q];
        illegal = (cur > 4'd9) || (idx_q[0] && (cur > 4'd5));
        blank   = (blink_phase_q && bus.blink_sel[idx_q])
               || (bus.blank_lead && (idx_q == 2'd3) && (snap_q[3] == 4'd0))
               || (bus.blank_lead && (idx_q == 2'd2) && (snap_q[3] == 4'd0)
                   && (snap_q[2] == 4'd0));
        an_d = ~(4'b0001 << idx_q);
        if (blank) begin
            seg_d = 7'h7F;
        end else if (illegal) begin
            seg_d = 7'h3F;
        end else begin
            seg_d = dec7(cur);
        end
        dp_d         = ~((idx_q == 2'd2) && bus.dp_en);
        frame_tick_d = wrap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q       <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            for (int i = 0; i < 4; i++) snap_q[i] <= '0;
            an_q          <= 4'b1111;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            frame_tick_q  <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            for (int i = 0; i < 4; i++) snap_q[i] <= snap_d[i];
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = frame_tick_q;
endmodule

// File: doc/stopwatch_display_scan.md
Name: stopwatch_display_scan

Overview:
Reads the four stopwatch digit counters (MM:SS: two mod-6 tens digits and two mod-10 ones digits) and drives a 4-digit common-anode 7-segment display by time-multiplexing.
Each frame it captures a coherent snapshot of all digits, so the display never shows a digit mix from two different counts.
It also provides leading-zero blanking, per-digit blinking for set mode, a minutes/seconds separator dot and a frame pulse.
It sits between the counter chain and the board display pins.

Parameters:
REFRESH_DIV, 50000, clocks each digit is displayed; minimum 2.
BLINK_DIV, 25, frames per blink half-period; minimum 1.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
sec_ones  input  4  BCD seconds ones, legal 0-9
sec_tens  input  4  seconds tens, legal 0-5
min_ones  input  4  BCD minutes ones, legal 0-9
min_tens  input  4  minutes tens, legal 0-5
blank_lead  input  1  enable leading-zero blanking of minute digits
blink_sel  input  4  per-digit blink mask, bit i = scan index i
dp_en  input  1  light the separator dot on the minutes-ones digit
an  output  4  digit enables, active-low, an[i] = scan index i
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low
frame_tick  output  1  one-cycle pulse at each frame wrap

Behaviour:
- Reset values: an=4'b1111, seg=7'h7F, dp=1, frame_tick=0. Internally: prescaler=0, index=0, blink_phase=0, blink_cnt=0, snapshot digits all 0. Reset asserted mid-frame clears everything immediately.
- Prescaler: counts 0..REFRESH_DIV-1. At the terminal count it wraps to 0 and the index advances 0->1->2->3->0.
- Index map: 0=sec_ones, 1=sec_tens, 2=min_ones, 3=min_tens.
- Snapshot: loaded from all four digit inputs on the edge where the prescaler is at terminal count and index=3, i.e. the same edge index wraps to 0. Input changes at any other time are invisible until the next wrap.
- frame_tick: high for exactly the one cycle following the wrap edge.
- Blink counter:
  - counts frames 0..BLINK_DIV-1 and increments on each wrap;
  - at its terminal count it returns to 0 and blink_phase toggles.
- Outputs are registered and lag the internal index/snapshot by one clock. an drives exactly one low bit (~(1<<index)) every cycle after the first post-reset edge.
- Blanking (seg=7'h7F while an stays active), checked in this order:
  - blink_phase=1 and blink_sel[index]=1;
  - blank_lead=1, index=3, snapshot min_tens=0;
  - blank_lead=1, index=2, snapshot min_tens=0 and min_ones=0.
  - Seconds digits are never lead-blanked.
- Decode (hex, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
- Illegal values show a dash (7'h3F): any value >9, or tens digits >5.
- dp=0 only when index=2 and dp_en=1; dp is not affected by blink or blanking. Otherwise dp=1.
- Inputs blank_lead, blink_sel and dp_en are used live (not snapshotted).
- Frame length is 4*REFRESH_DIV clocks. Blink period is 2*BLINK_DIV frames.

Test Plan:
- REFRESH_DIV=4, BLINK_DIV=2. Assert reset, release, digits 0 -> an=1110, seg=40 one clock after release. an steps 1101, 1011, 0111 every 4 clocks. frame_tick pulses at clock 16 after release.
- Digits min=1,2 sec=3,4 (min_tens=1, min_ones=2, sec_tens=3, sec_ones=4) held across a wrap -> next frame index0 seg=19, index1 seg=30, index2 seg=24, index3 seg=79.
- After snapshot of 12:34, change inputs to 55:55 at clock 5 of the frame -> the frame still shows 12:34. The following frame shows seg=12 on all digits.
- Digits 00:07, blank_lead=1 -> an=0111 and an=1011 slots show seg=7F. Digits 00:07, blank_lead=0 -> those slots show seg=40. Digits 05:07, blank_lead=1 -> only index3 is blanked.
- blink_sel=4'b0011, digits 12:34 -> index0/1 show normal patterns for frames 0-1, 7F for frames 2-3, normal again for frames 4-5. Index2/3 are never blanked. dp_en=1 -> dp=0 only in the an=1011 slot throughout.
- sec_tens=6 and sec_ones=12 -> seg=3F in both slots. Assert reset while an=1011 -> an=1111, seg=7F, dp=1 immediately. On release, scanning resumes at index0.
